// File: rtl/uart_hex_report_if.sv
// uart_hex_report_if: report-word handshake plus UART transmitter enable/busy byte port.
interface uart_hex_report_if;
  logic        Rpt_valid;
  logic [31:0] Rpt_data;
  logic        Rpt_ready;
  logic        Uart_TX_EN;
  logic [7:0]  Uart_din;
  logic        Uart_TX_busy;
  modport master (output Rpt_valid, Rpt_data, Uart_TX_busy, input Rpt_ready, Uart_TX_EN, Uart_din);
  modport slave  (input Rpt_valid, Rpt_data, Uart_TX_busy, output Rpt_ready, Uart_TX_EN, Uart_din);
endinterface

// File: rtl/uart_hex_report.sv
// uart_hex_report: formats a 32-bit report as "F:XXXXXXXX\r\n" for the UART transmitter; UART_RPT_CKSUM_EN adds "*CC".
module uart_hex_report (
  input logic CLK_SYS,
  input logic CLK_RST,
  uart_hex_report_if.slave bus
);
  localparam logic [7:0] TAG_CHAR = 8'h46;
  localparam logic [1:0] GAP_CYC = 2'd2;
`ifdef UART_RPT_CKSUM_EN
  localparam logic [3:0] LAST = 4'd14;
`else
  localparam logic [3:0] LAST = 4'd11;
`endif
  typedef enum logic [1:0] {IDLE, GAP, REQ, WAIT} state_t;
  state_t state, state_n;
  logic [3:0] idx, dig;
  logic [1:0] gap_cnt;
  logic [31:0] data;
  logic [7:0] din, ch;
  logic tx_en, ready, accept, load, tx_en_n, ready_n;
`ifdef UART_RPT_CKSUM_EN
  logic [7:0] cks;
`endif
  function automatic logic [7:0] hex(input logic [3:0] n);
    return n < 4'd10 ? {4'h3, n} : 8'h37 + {4'h0, n};
  endfunction
  assign accept = bus.Rpt_valid && ready;
  assign bus.Rpt_ready = ready;
  assign bus.Uart_TX_EN = tx_en;
  assign bus.Uart_din = din;
  always_comb begin
    dig = 4'd9 - idx;
    ch = idx == 4'd0 ? TAG_CHAR : idx == 4'd1 ? 8'h3A : idx <= 4'd9 ? hex(4'(data >> {dig, 2'b00})) :
         idx == LAST ? 8'h0A : 8'h0D;
`ifdef UART_RPT_CKSUM_EN
    ch = idx == 4'd10 ? 8'h2A : idx == 4'd11 ? hex(cks[7:4]) : idx == 4'd12 ? hex(cks[3:0]) : ch;
`endif
  end
  always_ff @(posedge CLK_SYS) begin
    if (CLK_RST) begin
      state <= IDLE;
      idx <= 4'd0;
      gap_cnt <= 2'd0;
      data <= 32'd0;
      din <= 8'h00;
      tx_en <= 1'b0;
      ready <= 1'b0;
`ifdef UART_RPT_CKSUM_EN
      cks <= 8'h00;
`endif
    end else begin
      state <= state_n;
      tx_en <= tx_en_n;
      ready <= ready_n;
      gap_cnt <= state != GAP ? 2'd0 : gap_cnt == GAP_CYC ? gap_cnt : gap_cnt + 2'd1;
      if (accept) begin
        data <= bus.Rpt_data;
        idx <= 4'd0;
      end
      if (state == WAIT && !bus.Uart_TX_busy && idx != LAST) idx <= idx + 4'd1;
      if (load) din <= ch;
`ifdef UART_RPT_CKSUM_EN
      if (accept) cks <= 8'h00;
      else if (load && idx <= 4'd9) cks <= cks ^ ch;
`endif
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = accept ? GAP : IDLE;
      GAP: state_n = gap_cnt == GAP_CYC && !bus.Uart_TX_busy ? REQ : GAP;
      REQ: state_n = bus.Uart_TX_busy ? WAIT : REQ;
      WAIT: state_n = bus.Uart_TX_busy ? WAIT : idx == LAST ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    load = state == GAP && state_n == REQ;
    tx_en_n = state_n == REQ;
    ready_n = state_n == IDLE;
  end
endmodule

// File: tb/tb_uart_hex_report.sv
// tb_uart_hex_report: random and directed report lines against a string-level line model and a transmitter model.
module tb_uart_hex_report;
  localparam int GAP_CYC = 2;
  localparam int LIMIT = 4000;
`ifdef UART_RPT_CKSUM_EN
  localparam int LEN = 15;
`else
  localparam int LEN = 12;
`endif
  logic clk = 0, rst = 1, busy = 0, prev_en = 0, rise;
  logic [7:0] din_hold = 0;
  logic [7:0] got[$];
  int rise_cyc[$];
  int checks = 0, failures = 0, cyc = 0;
  int viol_din = 0, viol_gap = 0, viol_busy = 0, low_cnt = 100, dly = 0, bl = 0, blen_max = 12;
  string last_line;
  uart_hex_report_if bus();
  assign bus.Uart_TX_busy = busy;
  uart_hex_report dut (.CLK_SYS(clk), .CLK_RST(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Bus monitor first, then the transmitter: busy 3 edges after the TX_EN rise, random length.
  always @(negedge clk) begin
    rise = bus.Uart_TX_EN && !prev_en;
    if (rst) din_hold = bus.Uart_din;
    else if (rise) begin
      if (low_cnt < GAP_CYC) viol_gap++;
      if (busy) viol_busy++;
      got.push_back(bus.Uart_din);
      rise_cyc.push_back(cyc);
      din_hold = bus.Uart_din;
    end else if ((bus.Uart_TX_EN || busy) && bus.Uart_din !== din_hold) viol_din++;
    low_cnt = bus.Uart_TX_EN ? 0 : low_cnt + 1;
    prev_en = bus.Uart_TX_EN;
    if (dly > 0) begin
      dly--;
      if (dly == 0) begin
        busy = 1;
        bl = $urandom_range(2, blen_max);
      end
    end else if (busy) begin
      bl--;
      if (bl == 0) busy = 0;
    end
    if (rise) dly = 2;
  end
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_s(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s observed=%s expected=%s", tag, obs, exp);
    end
  endtask
  function automatic string model(input logic [31:0] d);
    string hd = "0123456789ABCDEF";
    string s = "";
    logic [7:0] q[$];
`ifdef UART_RPT_CKSUM_EN
    logic [7:0] x = 0;
`endif
    q.push_back(8'h46);
    q.push_back(8'h3A);
    for (int i = 7; i >= 0; i--) q.push_back(hd[d[i*4 +: 4]]);
`ifdef UART_RPT_CKSUM_EN
    foreach (q[i]) x ^= q[i];
    q.push_back(8'h2A);
    q.push_back(hd[x[7:4]]);
    q.push_back(hd[x[3:0]]);
`endif
    q.push_back(8'h0D);
    q.push_back(8'h0A);
    foreach (q[i]) s = $sformatf("%s%02x ", s, q[i]);
    return s;
  endfunction
  task automatic send_line(input logic [31:0] d, input bit hold);
    int n, start, acc;
    logic busy_acc;
    string o = "";
    n = 0;
    while (!bus.Rpt_ready && n < LIMIT) begin step(); n++; end
    bus.Rpt_valid = 1;
    bus.Rpt_data = d;
    step();
    chk("accept_ready_low", bus.Rpt_ready, 0);
    acc = cyc;
    busy_acc = busy;
    start = got.size();
    if (hold) bus.Rpt_data = 32'h1;
    else begin
      bus.Rpt_valid = 0;
      bus.Rpt_data = $urandom;
    end
    n = 0;
    while (!bus.Rpt_ready && n < LIMIT) begin step(); n++; end
    chk("line_done", bus.Rpt_ready, 1);
    chk("rise_count", got.size() - start, LEN);
    chk("busy_at_ready", busy, 0);
    if (!busy_acc) chk("first_rise_latency", rise_cyc.size() > start ? rise_cyc[start] - acc : -1, GAP_CYC + 1);
    for (int i = start; i < start + LEN && i < got.size(); i++) o = $sformatf("%s%02x ", o, got[i]);
    last_line = o;
    chk_s($sformatf("line_%08h", d), o, model(d));
  endtask
  initial begin
    int n, start;
    bus.Rpt_valid = 0;
    bus.Rpt_data = 0;
    step();
    step();
    chk("rst_tx_en", bus.Uart_TX_EN, 0);
    chk("rst_din", bus.Uart_din, 8'h00);
    chk("rst_ready", bus.Rpt_ready, 0);
    rst = 0;
    step();
    chk("ready_after_rst", bus.Rpt_ready, 1);
    send_line(32'hDEADBEEF, 0);
`ifndef UART_RPT_CKSUM_EN
    chk_s("deadbeef_bytes", last_line, "46 3a 44 45 41 44 42 45 45 46 0d 0a ");
`endif
    send_line(32'h09AF0000, 0);
`ifndef UART_RPT_CKSUM_EN
    chk_s("hex_boundary_bytes", last_line, "46 3a 30 39 41 46 30 30 30 30 0d 0a ");
`endif
    send_line(32'h12345678, 1);
    send_line(32'h00000001, 0);
    blen_max = 40;
    bus.Rpt_valid = 1;
    bus.Rpt_data = $urandom;
    step();
    bus.Rpt_valid = 0;
    start = got.size();
    n = 0;
    while (!(got.size() >= start + 6 && busy) && n < LIMIT) begin step(); n++; end
    chk("midline_reached", n < LIMIT, 1);
    rst = 1;
    step();
    chk("midline_rst_tx_en", bus.Uart_TX_EN, 0);
    chk("midline_rst_ready", bus.Rpt_ready, 0);
    rst = 0;
    step();
    chk("midline_ready_after", bus.Rpt_ready, 1);
    send_line($urandom, 0);
    blen_max = 12;
    for (int k = 0; k < 4; k++) send_line($urandom, 0);
`ifdef UART_RPT_CKSUM_EN
    send_line(32'h0000000A, 0);
    chk_s("cksum_bytes", last_line, "46 3a 30 30 30 30 30 30 30 41 2a 30 44 0d 0a ");
`endif
    chk("din_stable", viol_din, 0);
    chk("gap_low_cycles", viol_gap, 0);
    chk("rise_while_busy", viol_busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
